// File: rtl/keypad_matrix_scanner.sv
// 4x3 matrix keypad scanner: drives one column low at a time, samples the
// rows, rejects ghosts (more than one digit key) and bounce, and presents a
// registered one-hot digit vector plus a strobe on each new nonzero digit.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       clrn,
    input  logic [3:0] rows_n,
    output logic [2:0] cols_n,
    output logic [9:0] keypad,
    output logic       key_strobe
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_t;

    col_t          r_col;
    col_t          w_col_next;
    logic [2:0]    r_cols_n;
    logic [2:0]    w_cols_n_next;
    logic [DW-1:0] r_div;
    logic [9:0]    r_acc;
    logic [1:0]    r_cnt;
    logic [9:0]    r_last;
    logic [SW-1:0] r_stable;
    logic [9:0]    r_keypad;
    logic          r_strobe;

    logic          w_tc;
    logic          w_scan_end;
    logic [9:0]    w_col_bits;
    logic [2:0]    w_hits;
    logic [2:0]    w_sum;
    logic [1:0]    w_cnt_total;
    logic [9:0]    w_acc_total;
    logic [9:0]    w_candidate;

    assign w_tc       = (r_div == DW'(SCAN_DIV - 1));
    assign w_scan_end = w_tc && (r_col == COL2);

    // Column sequencing, row decode for the driven column, and scan-total math.
    always_comb begin
        w_col_next    = r_col;
        w_cols_n_next = r_cols_n;
        w_col_bits    = 10'b0;
        w_hits        = 3'd0;
        if (w_tc) begin
            case (r_col)
                COL0:    w_col_next = COL1;
                COL1:    w_col_next = COL2;
                default: w_col_next = COL0;
            endcase
        end
        case (w_col_next)
            COL0:    w_cols_n_next = 3'b110;
            COL1:    w_cols_n_next = 3'b101;
            default: w_cols_n_next = 3'b011;
        endcase
        // Row 3 only carries a digit in the middle column ('0'); '*' and '#'
        // are invisible here so they never contribute to ghost detection.
        case (r_col)
            COL0: begin
                w_col_bits[1] = ~rows_n[0];
                w_col_bits[4] = ~rows_n[1];
                w_col_bits[7] = ~rows_n[2];
            end
            COL1: begin
                w_col_bits[2] = ~rows_n[0];
                w_col_bits[5] = ~rows_n[1];
                w_col_bits[8] = ~rows_n[2];
                w_col_bits[0] = ~rows_n[3];
            end
            default: begin
                w_col_bits[3] = ~rows_n[0];
                w_col_bits[6] = ~rows_n[1];
                w_col_bits[9] = ~rows_n[2];
            end
        endcase
        for (int i = 0; i < 10; i++) begin
            w_hits = w_hits + {2'b0, w_col_bits[i]};
        end
        w_sum       = {1'b0, r_cnt} + w_hits;
        w_cnt_total = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_acc_total = r_acc | w_col_bits;
        w_candidate = (w_cnt_total == 2'd1) ? w_acc_total : 10'b0;
    end

    // Column state register and registered column drive pins.
    always_ff @(posedge clock) begin
        if (!clrn) begin
            r_col    <= COL0;
            r_cols_n <= 3'b110;
        end else begin
            r_col    <= w_col_next;
            r_cols_n <= w_cols_n_next;
        end
    end

    // Per-column settle divider.
    always_ff @(posedge clock) begin
        if (!clrn) begin
            r_div <= '0;
        end else if (w_tc) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Scan accumulation and debounce of the per-scan candidate into keypad.
    always_ff @(posedge clock) begin
        if (!clrn) begin
            r_acc    <= 10'b0;
            r_cnt    <= 2'd0;
            r_last   <= 10'b0;
            r_stable <= '0;
            r_keypad <= 10'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_scan_end) begin
                r_acc <= 10'b0;
                r_cnt <= 2'd0;
                if (w_candidate != r_last) begin
                    r_last   <= w_candidate;
                    r_stable <= '0;
                end else if (r_stable < SW'(DEBOUNCE - 1)) begin
                    r_stable <= r_stable + SW'(1);
                end else if (w_candidate != r_keypad) begin
                    r_keypad <= w_candidate;
                    r_strobe <= (w_candidate != 10'b0);
                end
            end else if (w_tc) begin
                r_acc <= w_acc_total;
                r_cnt <= w_cnt_total;
            end
        end
    end

    assign cols_n     = r_cols_n;
    assign keypad     = r_keypad;
    assign key_strobe = r_strobe;

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Drives and reads the oven's physical 4x3 matrix keypad and produces the debounced one-hot keypad[9:0] vector consumed by the timer-entry encoder. It is the producer end of the keypad interface: it scans columns, samples rows, rejects bounce and multi-key ghosts, and holds the digit code while the key is held. It sits between the board pins and encoder_timer_input_control, on the system clock.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled (>=2)
DEBOUNCE, 4, consecutive identical full scans required before the output changes (>=1)

Ports:
clock  input  1  system clock, all state updates on posedge
clrn  input  1  synchronous active-low reset, sampled on posedge clock
rows_n  input  4  row lines, active-low (pulled up externally); bit r = row r
cols_n  output  3  column drives, active-low, exactly one bit low at all times
keypad  output  10  debounced one-hot digit, active-high; bit d = digit d; all-zero = no valid key
key_strobe  output  1  one-cycle pulse when keypad takes a new nonzero value

Behaviour:
- Key map (row,col): r0: 1 2 3; r1: 4 5 6; r2: 7 8 9; r3: * 0 #. The * and # keys are ignored: they never set any bit and do not count toward multi-key detection.
- Reset (clrn=0 at posedge): cols_n=3'b110 (col0), div counter=0, column index=0, scan accumulator=0, last candidate=0, stable count=0, keypad=0, key_strobe=0. Reset overrides every other action, including a press in progress.
- Divider: counts 0..SCAN_DIV-1. At terminal count, rows_n is sampled for the current column, the decoded digit bits are ORed into the accumulator, and the digit count is added (saturating at 2). On the same edge the column advances 0->1->2->0 (cols_n 110->101->011->110) and the divider returns to 0. Each column is driven for exactly SCAN_DIV cycles, so sampling happens after SCAN_DIV-1 cycles of settling.
- Scan end (the edge that samples col2):
  - candidate = accumulated one-hot if the digit count is exactly 1, else 10'b0 (none or ghost). Accumulator and count clear for the next scan.
  - If candidate != last candidate: last candidate := candidate, stable count := 0, and keypad is unchanged.
  - Else if stable count < DEBOUNCE-1: stable count increments.
  - Else (stable): if candidate != keypad, then keypad := candidate, and key_strobe := 1 for that cycle only if candidate != 0. The stable count holds.
- Latency: a press clean before a scan starts commits at the end of scan number DEBOUNCE (first matching scan counts as 1 only if last candidate already equals it; otherwise at the end of scan DEBOUNCE+1). The worst case is (DEBOUNCE+2)*3*SCAN_DIV cycles. Release uses the same rule toward 0, with no strobe.
- Key change without release (5 then 8 held): keypad goes directly 5->8 after debounce, and strobe pulses once.
- Two digit keys held: keypad debounces to 0. When one is released, the remaining key commits with a strobe.
- key_strobe is 0 in every other cycle. keypad is a register, glitch-free, and stable between scan ends.
- rows_n is assumed already synchronous to clock (a 2-FF synchronizer is upstream, outside this block).

Test Plan:
(SCAN_DIV=4, DEBOUNCE=3, scan = 12 cycles)
- Reset, no keys -> cols_n cycles 110,101,011 with 4 cycles each. keypad=0 and key_strobe=0 for 200 cycles.
- Hold '5' (rows_n[1]=0 while cols_n[1]=0) from a scan boundary -> keypad=10'b0000100000 at the end of scan 4 (cycle 48). Exactly one key_strobe. Release -> keypad=0 after 4 more scans, no strobe.
- '3' bounces (toggle every 5 cycles for 30 cycles, then solid) -> exactly one strobe. keypad=10'b0000001000 only after 3 identical clean scans.
- '1'+'9' held together -> keypad stays 0 and no strobe. Release '1' -> keypad=10'b1000000000 with one strobe.
- '*' or '#' held alone for 100 cycles -> keypad=0, no strobe. '0' held together with '*' -> keypad=10'b0000000001.
- Reset asserted while '7' is committed and still held -> on the next edge keypad=0 and cols_n=110. After clrn=1, keypad re-commits to 10'b0010000000 with a fresh strobe.
